uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: next generation of the fixed 8N1 receiver in the pong control path.
//  Adds configurable data width, parity and stop bits, an input synchroniser and 3-sample majority voting.
//  Adds a valid/ready output handshake with parity, framing and overrun error flags.
//  Sits between the board RX pin and the command decoder that moves the paddles.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock in Hz
//  BAUD_RATE   115200      line rate; localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (434), HALF = CLKS_PER_BIT/2
//  DATA_BITS   8           payload bits per frame, legal range 5..9
//  PARITY      0           0 = none, 1 = odd, 2 = even
//  STOP_BITS   1           1 or 2
// PORTS
//  clk_in          in   1          system clock, all logic on rising edge
//  rst_in          in   1          synchronous reset, active-high
//  serial_data_in  in   1          asynchronous RX line, idle high
//  data_ready_in   in   1          consumer accepts data_byte_op this cycle
//  data_valid      out  1          data_byte_op/parity_err/frame_err hold a received frame
//  data_byte_op    out  DATA_BITS  received payload, bit 0 = first bit on line (LSB first)
//  parity_err      out  1          parity mismatch on held frame; forced 0 when PARITY = 0
//  frame_err       out  1          a stop bit sampled low on held frame
//  overrun_err     out  1          one-cycle pulse: frame completed while previous frame still held
//  busy            out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset: both sync flops = 1, FSM = IDLE, counters = 0, all outputs = 0. Reset mid-frame aborts the frame, nothing is delivered.
//  - serial_data_in passes 2 flops (rx_s). All sampling uses rx_s.
//  - bit_cnt runs 0..CLKS_PER_BIT-1 per bit, restarting at 0 on each bit boundary.
//  - Bit value = majority of rx_s at bit_cnt HALF-1, HALF and HALF+1. The value is decided at HALF+1.
//  - FSM states:
//    IDLE -> START when rx_s == 0, bit_cnt = 0.
//    START: at HALF+1, majority 1 -> IDLE (glitch, no output). Majority 0 -> continue; at CLKS_PER_BIT-1 -> DATA.
//    DATA: shift one bit per bit period into shift register, LSB first. After DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
//    PARITY: compare sampled bit with XOR of data (odd: total ones incl. parity odd; even: even).
//    STOP: STOP_BITS periods; any stop bit majority 0 sets frame_err_nxt. Completion is at HALF+1 of the LAST stop bit, not end of period:
//      completion with no error -> IDLE (allows back-to-back frames);
//      completion with frame_err_nxt -> WAIT_IDLE.
//    WAIT_IDLE: stay until rx_s == 1 (break/stuck-low line), then -> IDLE. No new start is detected here.
//  - Delivery at completion:
//    if data_valid == 0, or data_valid & data_ready_in in the same cycle: next cycle data_valid = 1 and
//      data_byte_op/parity_err/frame_err load the new frame.
//    else: held frame unchanged, new frame dropped, overrun_err = 1 for exactly that next cycle.
//  - Frames with errors are still delivered, flags set alongside.
//  - Handshake: transfer when data_valid & data_ready_in. data_valid drops the next cycle unless a new frame loads in that same cycle.
//    data_byte_op and error flags stay stable while data_valid = 1 and not accepted.
//  - Latency, first cycle rx_s == 0 to data_valid = 1:
//    (1 + DATA_BITS + (PARITY != 0) + STOP_BITS - 1) * CLKS_PER_BIT + HALF + 2 cycles (plus 2 sync cycles from pin).
//  - When DATA_BITS = 9, data_byte_op is 9 bits wide. No truncation anywhere.
// TESTING
//  T1 8N1, send 0x55, data_ready_in = 1 -> data_valid high 1 cycle; data_byte_op = 0x55; parity/frame/overrun = 0;
//     latency per formula (9*434 + 217 + 2 + 2 sync).
//  T2 line low 100 clk then high -> START aborts at HALF+1, no data_valid, busy returns 0.
//  T3 PARITY = 2, send 0xA3 with parity bit 1 (wrong) -> data_valid, data_byte_op = 0xA3, parity_err = 1.
//  T4 send 0x7E with stop bit 0, line held low 3000 clk -> frame_err = 1, FSM in WAIT_IDLE until line high, then new 0x12 received cleanly.
//  T5 data_ready_in = 0, frames 0xA5 then 0x3C back-to-back -> data_byte_op stays 0xA5, overrun_err pulses 1 cycle;
//     raising ready then yields data_valid = 0.
//  T6 1-cycle high spike at HALF of data bit 3 of 0x00 -> majority yields 0x00. Also: rst_in mid-frame -> no data_valid, next 0xC3 ok.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: RX line and ready in, delivered frame, error flags and busy out.
// The receiver takes the slave modport; the line driver and consumer take the master modport.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_data_in;
  logic                 data_ready_in;
  logic                 data_valid;
  logic [DATA_BITS-1:0] data_byte_op;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 busy;

  modport master (
    output serial_data_in,
    output data_ready_in,
    input  data_valid,
    input  data_byte_op,
    input  parity_err,
    input  frame_err,
    input  overrun_err,
    input  busy
  );

  modport slave (
    input  serial_data_in,
    input  data_ready_in,
    output data_valid,
    output data_byte_op,
    output parity_err,
    output frame_err,
    output overrun_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority per bit,
// optional parity, 1 or 2 stop bits, and a one-deep valid/ready output holding register.
module uart_rx_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  uart_rx_param_if.slave rx
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for this payload.
  function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) return ~^d;
    return ^d;
  endfunction

  logic                 rx_sync_p0, rx_s;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 samp0, samp1;
  logic                 sample_now, maj, done;

  logic                 vld_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_out_q, ferr_out_q, ovr_q;

  assign sample_now = (cnt_q == CNT_S2);
  assign maj        = maj3(samp0, samp1, rx_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    idx_d   = idx_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    case (state_q)
      // The cycle that first sees the line low counts as sample 0 of the start bit.
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_ONE;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (sample_now && maj) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_now) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (cnt_q == CNT_LAST) begin
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      PAR: begin
        if (sample_now) perr_d = (maj != exp_parity(shreg_q));
        if (cnt_q == CNT_LAST) state_d = STOP;
      end
      // The frame completes mid-way through the last stop bit so the next start edge is never missed.
      STOP: begin
        if (sample_now) begin
          if (!maj) ferr_d = 1'b1;
          if (idx_q == STOP_LAST) begin
            done    = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = (ferr_q || !maj) ? WAIT_IDLE : IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // p0 -> rx_s: synchroniser; FSM and output register sample rx_s only
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      vld_q      <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_sync_p0 <= rx.serial_data_in;
      rx_s       <= rx_sync_p0;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      if (done && (!vld_q || rx.data_ready_in)) begin
        vld_q      <= 1'b1;
        data_q     <= shreg_q;
        perr_out_q <= (PARITY != 0) && perr_q;
        ferr_out_q <= ferr_d;
        ovr_q      <= 1'b0;
      end else begin
        ovr_q <= done;
        if (vld_q && rx.data_ready_in) vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    shreg_q <= shreg_d;
    if (cnt_q == CNT_S0) samp0 <= rx_s;
    if (cnt_q == CNT_S1) samp1 <= rx_s;
  end

  assign rx.data_valid   = vld_q;
  assign rx.data_byte_op = data_q;
  assign rx.parity_err   = perr_out_q;
  assign rx.frame_err    = ferr_out_q;
  assign rx.overrun_err  = ovr_q;
  assign rx.busy         = (state_q != IDLE);
endmodule
